// File: rtl/three_bit_sort_scheduler.sv
// Frame sorter: loads DEPTH 3-bit words, bubble-sorts them with one shared
// magnitude comparator (one compare-and-swap per clock), then streams them out.
module three_bit_sort_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [2:0] out_data,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic [5:0] swap_count
);
    localparam int DATA_W = 3;
    localparam int IDX_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_CMP  = IDX_W'(DEPTH - 2);
    localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
    typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_t;

    // The single shared Greater/Equal/Less decoder.
    function automatic cmp_t compare3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (a > b)
            return CMP_GT;
        else if (a == b)
            return CMP_EQ;
        else
            return CMP_LT;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  cmp_idx;
    logic [IDX_W-1:0]  cmp_nxt;
    logic [IDX_W-1:0]  pass_cnt;
    logic              pass_swap;
    logic              do_swap;

    always_comb begin
        cmp_nxt = cmp_idx + IDX_W'(1);
        do_swap = (compare3(mem[cmp_idx], mem[cmp_nxt]) == CMP_GT);
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign out_data  = (state == DRAIN) ? mem[rd_idx] : '0;
    assign out_last  = (state == DRAIN) && (rd_idx == LAST_IDX);
    assign busy      = (state == SORT) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            wr_idx     <= '0;
            rd_idx     <= '0;
            cmp_idx    <= '0;
            pass_cnt   <= '0;
            pass_swap  <= 1'b0;
            swap_count <= '0;
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        mem[wr_idx] <= in_data;
                        if (wr_idx == LAST_IDX) begin
                            wr_idx     <= '0;
                            cmp_idx    <= '0;
                            pass_cnt   <= '0;
                            pass_swap  <= 1'b0;
                            swap_count <= '0;
                            state      <= SORT;
                        end else begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        mem[cmp_idx] <= mem[cmp_nxt];
                        mem[cmp_nxt] <= mem[cmp_idx];
                        swap_count   <= sat_inc(swap_count);
                    end
                    // Pass boundary: stop on a clean pass or after DEPTH-1 passes.
                    if (cmp_idx == LAST_CMP) begin
                        cmp_idx   <= '0;
                        pass_swap <= 1'b0;
                        if (!(pass_swap || do_swap) || pass_cnt == LAST_PASS) begin
                            pass_cnt <= '0;
                            rd_idx   <= '0;
                            state    <= DRAIN;
                        end else begin
                            pass_cnt <= pass_cnt + IDX_W'(1);
                        end
                    end else begin
                        cmp_idx   <= cmp_nxt;
                        pass_swap <= pass_swap || do_swap;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_three_bit_sort_scheduler.sv
// Directed bench for three_bit_sort_scheduler (DEPTH=4): load, sort timing,
// drain with backpressure, input gaps and mid-sort reset.
module tb_three_bit_sort_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic [5:0] swap_count;

    int compared = 0;
    int mismatched = 0;

    three_bit_sort_scheduler #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .swap_count(swap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pack(input logic [2:0] a, input logic [2:0] b,
                                         input logic [2:0] c, input logic [2:0] d);
        return {d, c, b, a};
    endfunction

    // Inputs change on the falling edge; outputs are checked there too.
    task automatic load_words(input logic [11:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = 3'd1;
                @(negedge clk);
            end
            check("load_in_ready", {7'd0, in_ready}, 8'd1);
            in_valid = 1'b1;
            in_data  = w[3*i +: 3];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 3'd0;
    endtask

    task automatic wait_sort(input int exp_cycles, input bit noise);
        int cycles = 0;
        if (noise) begin
            in_valid  = 1'b1;
            in_data   = 3'd7;
            out_ready = 1'b1;
        end
        while (out_valid !== 1'b1 && cycles < 40) begin
            if (cycles == 0) begin
                check("sort_in_ready", {7'd0, in_ready}, 8'd0);
                check("sort_busy", {7'd0, busy}, 8'd1);
                check("sort_entry_swaps", {2'd0, swap_count}, 8'd0);
            end
            cycles++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("sort_cycles", 8'(cycles), 8'(exp_cycles));
    endtask

    task automatic drain_words(input logic [11:0] e, input int exp_swaps,
                               input bit stall, input bit noise);
        int step = 0;
        int guard = 0;
        check("drain_entry_swaps", {2'd0, swap_count}, 8'(exp_swaps));
        for (int k = 0; k < 4; k++) begin
            do begin
                out_ready = stall ? (step % 4 == 0 || step % 4 == 3) : 1'b1;
                step++;
                guard++;
                check("drain_valid", {7'd0, out_valid}, 8'd1);
                check("drain_data", {5'd0, out_data}, {5'd0, e[3*k +: 3]});
                check("drain_last", {7'd0, out_last}, (k == 3) ? 8'd1 : 8'd0);
                check("drain_in_ready", {7'd0, in_ready}, 8'd0);
                @(negedge clk);
            end while (out_ready !== 1'b1 && guard < 64);
        end
        out_ready = 1'b0;
        if (noise) begin
            in_valid = 1'b0;
            in_data  = 3'd0;
        end
        check("post_in_ready", {7'd0, in_ready}, 8'd1);
        check("post_out_valid", {7'd0, out_valid}, 8'd0);
        check("post_out_data", {5'd0, out_data}, 8'd0);
        check("post_busy", {7'd0, busy}, 8'd0);
        check("post_swaps", {2'd0, swap_count}, 8'(exp_swaps));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 3'd0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_out_data", {5'd0, out_data}, 8'd0);
        check("rst_out_last", {7'd0, out_last}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_swaps", {2'd0, swap_count}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);

        // 4,7,1,3 -> 1,3,4,7
        load_words(pack(3'd4, 3'd7, 3'd1, 3'd3), 1'b0);
        wait_sort(9, 1'b0);
        drain_words(pack(3'd1, 3'd3, 3'd4, 3'd7), 4, 1'b0, 1'b0);

        // Presorted frame with in_valid/out_ready noise during SORT and DRAIN
        load_words(pack(3'd1, 3'd2, 3'd5, 3'd6), 1'b0);
        wait_sort(3, 1'b1);
        in_valid = 1'b1;
        in_data  = 3'd7;
        drain_words(pack(3'd1, 3'd2, 3'd5, 3'd6), 0, 1'b0, 1'b1);

        // Worst case
        load_words(pack(3'd7, 3'd5, 3'd3, 3'd0), 1'b0);
        wait_sort(9, 1'b0);
        drain_words(pack(3'd0, 3'd3, 3'd5, 3'd7), 6, 1'b0, 1'b0);

        // Duplicates with output stalls 1,0,0,1,...
        load_words(pack(3'd6, 3'd2, 3'd6, 3'd2), 1'b0);
        wait_sort(9, 1'b0);
        drain_words(pack(3'd2, 3'd2, 3'd6, 3'd6), 3, 1'b1, 1'b0);

        // All equal, gaps between valid words
        load_words(pack(3'd5, 3'd5, 3'd5, 3'd5), 1'b1);
        wait_sort(3, 1'b0);
        drain_words(pack(3'd5, 3'd5, 3'd5, 3'd5), 0, 1'b0, 1'b0);

        // Reset in the middle of SORT
        load_words(pack(3'd7, 3'd5, 3'd3, 3'd0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("midsort_busy", {7'd0, busy}, 8'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {7'd0, out_valid}, 8'd0);
        check("midrst_out_data", {5'd0, out_data}, 8'd0);
        check("midrst_busy", {7'd0, busy}, 8'd0);
        check("midrst_swaps", {2'd0, swap_count}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {7'd0, in_ready}, 8'd1);
        load_words(pack(3'd3, 3'd1, 3'd2, 3'd0), 1'b0);
        wait_sort(9, 1'b0);
        drain_words(pack(3'd0, 3'd1, 3'd2, 3'd3), 5, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
